// File: rtl/jpeg_sof_parser_n_pkg.sv
// rtl/jpeg_sof_parser_n_pkg.sv - shared states, error codes and helpers for the SOFn parser
package jpeg_sof_parser_n_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_PREC,
      S_Y_HI,
      S_Y_LO,
      S_X_HI,
      S_X_LO,
      S_NCOMP,
      S_C_ID,
      S_C_HV,
      S_C_TQ,
      S_CALC,
      S_DONE,
      S_DRAIN,
      S_ERR
   } sof_state_t;

   localparam logic [2:0] ERR_NONE       = 3'd0;
   localparam logic [2:0] ERR_BAD_LEN    = 3'd1;
   localparam logic [2:0] ERR_BAD_PREC   = 3'd2;
   localparam logic [2:0] ERR_BAD_NCOMP  = 3'd3;
   localparam logic [2:0] ERR_BAD_FACTOR = 3'd4;
   localparam logic [2:0] ERR_BAD_TQ     = 3'd5;
   localparam logic [2:0] ERR_ZERO_DIM   = 3'd6;

   // Lf of a header with zero components: Lf(2) + P(1) + Y(2) + X(2) + Nf(1)
   localparam logic [15:0] LF_BASE = 16'd8;

   // Only power-of-two factors are supported so MCU geometry stays shift-based
   function automatic logic factor_ok(input logic [3:0] f);
      return (f == 4'd1) || (f == 4'd2) || (f == 4'd4);
   endfunction

   function automatic logic [2:0] factor_log2(input logic [2:0] f);
      case (f)
         3'd2:    return 3'd1;
         3'd4:    return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/jpeg_mcu_count.sv
// rtl/jpeg_mcu_count.sv - ceil(dim / (8*fmax)) for one axis, fmax in {1,2,4}
module jpeg_mcu_count
   import jpeg_sof_parser_n_pkg::*;
(
   input  logic [15:0] dim,
   input  logic [2:0]  fmax,
   output logic [12:0] count
);

   logic [16:0] sum;
   logic [2:0]  sh;

   // 17-bit sum so a 16-bit dimension plus the rounding term cannot wrap
   always_comb begin
      sh    = 3'd3 + factor_log2(fmax);
      sum   = {1'b0, dim} + {11'd0, fmax, 3'b000} - 17'd1;
      count = 13'(sum >> sh);
   end

endmodule

// File: rtl/jpeg_sof_parser_n.sv
// rtl/jpeg_sof_parser_n.sv - SOFn frame-header parser: byte-stream FSM, header validation, MCU geometry
module jpeg_sof_parser_n
   import jpeg_sof_parser_n_pkg::*;
#(
   parameter int MAX_COMP  = 3,
   parameter int ONLY_8BIT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    start,
   input  logic                    in_valid,
   input  logic [7:0]              in_data,
   output logic                    in_ready,
   output logic                    sof_valid,
   output logic                    sof_err,
   output logic [2:0]              err_code,
   output logic [7:0]              precision,
   output logic [15:0]             height,
   output logic [15:0]             width,
   output logic [2:0]              num_comp,
   output logic [8*MAX_COMP-1:0]   comp_id,
   output logic [3*MAX_COMP-1:0]   comp_h,
   output logic [3*MAX_COMP-1:0]   comp_v,
   output logic [2*MAX_COMP-1:0]   comp_tq,
   output logic [2:0]              h_max,
   output logic [2:0]              v_max,
   output logic [12:0]             mcus_x,
   output logic [12:0]             mcus_y,
   output logic                    pic_is_420
);

   sof_state_t  state;
   logic [15:0] lf;
   logic [15:0] cnt;
   logic [15:0] cnt_nx;
   logic [1:0]  k;
   logic [2:0]  bad_code;
   logic        accept;
   logic [12:0] mx_nx;
   logic [12:0] my_nx;

   assign in_ready = ((state >= S_LEN_HI) && (state <= S_C_TQ)) || (state == S_DRAIN);
   assign accept   = in_valid && in_ready;
   assign cnt_nx   = cnt - 16'd1;

   jpeg_mcu_count u_mcu_x (
      .dim   (width),
      .fmax  (h_max),
      .count (mx_nx)
   );

   jpeg_mcu_count u_mcu_y (
      .dim   (height),
      .fmax  (v_max),
      .count (my_nx)
   );

   // Validation of the byte currently offered; only acted on when accepted
   always_comb begin
      bad_code = ERR_NONE;
      case (state)
         S_LEN_LO: begin
            if ({lf[15:8], in_data} < LF_BASE) bad_code = ERR_BAD_LEN;
         end
         S_PREC: begin
            if ((ONLY_8BIT != 0) && (in_data != 8'd8)) bad_code = ERR_BAD_PREC;
         end
         S_NCOMP: begin
            if ((in_data == 8'd0) || (in_data > 8'(MAX_COMP)))
               bad_code = ERR_BAD_NCOMP;
            else if (lf != LF_BASE + 16'(in_data) * 16'd3)
               bad_code = ERR_BAD_LEN;
         end
         S_C_HV: begin
            if (!factor_ok(in_data[7:4]) || !factor_ok(in_data[3:0])) bad_code = ERR_BAD_FACTOR;
         end
         S_C_TQ: begin
            if (in_data[7:2] != 6'd0) bad_code = ERR_BAD_TQ;
         end
         default: bad_code = ERR_NONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst || clear || start) begin
         state      <= (!rst || clear) ? S_IDLE : S_LEN_HI;
         lf         <= '0;
         cnt        <= '0;
         k          <= '0;
         sof_valid  <= 1'b0;
         sof_err    <= 1'b0;
         err_code   <= ERR_NONE;
         precision  <= '0;
         height     <= '0;
         width      <= '0;
         num_comp   <= '0;
         comp_id    <= '0;
         comp_h     <= '0;
         comp_v     <= '0;
         comp_tq    <= '0;
         h_max      <= '0;
         v_max      <= '0;
         mcus_x     <= '0;
         mcus_y     <= '0;
         pic_is_420 <= 1'b0;
      end else if (state == S_CALC) begin
         if ((width == 16'd0) || (height == 16'd0)) begin
            sof_err  <= 1'b1;
            err_code <= ERR_ZERO_DIM;
            state    <= S_ERR;
         end else begin
            mcus_x     <= mx_nx;
            mcus_y     <= my_nx;
            pic_is_420 <= (h_max == 3'd2) && (v_max == 3'd2);
            sof_valid  <= 1'b1;
            state      <= S_DONE;
         end
      end else if (accept) begin
         // Every byte after Lf counts against the remaining segment length
         if ((state != S_LEN_HI) && (state != S_LEN_LO)) cnt <= cnt_nx;
         if (bad_code != ERR_NONE) begin
            sof_err  <= 1'b1;
            err_code <= bad_code;
            // A bad Lf gives no trustworthy length to drain against
            state    <= ((state == S_LEN_LO) || (cnt_nx == 16'd0)) ? S_ERR : S_DRAIN;
         end else begin
            case (state)
               S_LEN_HI: begin
                  lf[15:8] <= in_data;
                  state    <= S_LEN_LO;
               end
               S_LEN_LO: begin
                  lf[7:0] <= in_data;
                  cnt     <= {lf[15:8], in_data} - 16'd2;
                  state   <= S_PREC;
               end
               S_PREC: begin
                  precision <= in_data;
                  state     <= S_Y_HI;
               end
               S_Y_HI: begin
                  height[15:8] <= in_data;
                  state        <= S_Y_LO;
               end
               S_Y_LO: begin
                  height[7:0] <= in_data;
                  state       <= S_X_HI;
               end
               S_X_HI: begin
                  width[15:8] <= in_data;
                  state       <= S_X_LO;
               end
               S_X_LO: begin
                  width[7:0] <= in_data;
                  state      <= S_NCOMP;
               end
               S_NCOMP: begin
                  num_comp <= in_data[2:0];
                  k        <= '0;
                  state    <= S_C_ID;
               end
               S_C_ID: begin
                  comp_id[8*k +: 8] <= in_data;
                  state             <= S_C_HV;
               end
               S_C_HV: begin
                  comp_h[3*k +: 3] <= in_data[6:4];
                  comp_v[3*k +: 3] <= in_data[2:0];
                  if (in_data[6:4] > h_max) h_max <= in_data[6:4];
                  if (in_data[2:0] > v_max) v_max <= in_data[2:0];
                  state <= S_C_TQ;
               end
               S_C_TQ: begin
                  comp_tq[2*k +: 2] <= in_data[1:0];
                  if ({1'b0, k} == num_comp - 3'd1) begin
                     state <= S_CALC;
                  end else begin
                     k     <= k + 2'd1;
                     state <= S_C_ID;
                  end
               end
               S_DRAIN: begin
                  if (cnt_nx == 16'd0) state <= S_ERR;
               end
               default: state <= state;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jpeg_sof_parser_n.sv
// tb/tb_jpeg_sof_parser_n.sv - randomized and directed bench for jpeg_sof_parser_n
module tb_jpeg_sof_parser_n;

   localparam int MAX_COMP = 3;

   logic                  clk = 1'b0;
   logic                  rst, clear, start, in_valid;
   logic [7:0]            in_data;
   logic                  in_ready, sof_valid, sof_err, pic_is_420;
   logic [2:0]            err_code, num_comp, h_max, v_max;
   logic [7:0]            precision;
   logic [15:0]           height, width;
   logic [8*MAX_COMP-1:0] comp_id;
   logic [3*MAX_COMP-1:0] comp_h, comp_v;
   logic [2*MAX_COMP-1:0] comp_tq;
   logic [12:0]           mcus_x, mcus_y;

   int n_checks = 0;
   int n_errors = 0;

   typedef logic [7:0] byte_q_t[$];

   typedef struct packed {
      logic        ok;
      logic [2:0]  code;
      int          err_idx;
      int          consumed;
      int          prec;
      int          ht;
      int          wd;
      int          nf;
      logic [31:0] ids;
      logic [31:0] hs;
      logic [31:0] vs;
      logic [31:0] tqs;
      int          hmax;
      int          vmax;
      int          mx;
      int          my;
      logic        is420;
   } exp_t;

   jpeg_sof_parser_n #(.MAX_COMP(MAX_COMP), .ONLY_8BIT(1)) dut (
      .clk(clk), .rst(rst), .clear(clear), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .sof_valid(sof_valid), .sof_err(sof_err), .err_code(err_code),
      .precision(precision), .height(height), .width(width), .num_comp(num_comp),
      .comp_id(comp_id), .comp_h(comp_h), .comp_v(comp_v), .comp_tq(comp_tq),
      .h_max(h_max), .v_max(v_max), .mcus_x(mcus_x), .mcus_y(mcus_y),
      .pic_is_420(pic_is_420)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit fac_ok(input int f);
      return (f == 1) || (f == 2) || (f == 4);
   endfunction

   // Reference: walk the header with the plain rules; first error wins
   function automatic exp_t model(input byte_q_t hb);
      exp_t e;
      int lf, h, v, tq;
      e = '0;
      e.err_idx = -2;
      lf = {hb[0], hb[1]};
      e.consumed = lf;
      if (lf < 8) begin
         e.code = 3'd1; e.err_idx = 1; e.consumed = 2;
         return e;
      end
      e.prec = hb[2];
      if (hb[2] != 8) begin
         e.code = 3'd2; e.err_idx = 2;
         return e;
      end
      e.ht = {hb[3], hb[4]};
      e.wd = {hb[5], hb[6]};
      e.nf = hb[7];
      if (e.nf == 0 || e.nf > MAX_COMP) begin
         e.code = 3'd3; e.err_idx = 7;
         return e;
      end
      if (lf != 8 + 3 * e.nf) begin
         e.code = 3'd1; e.err_idx = 7;
         return e;
      end
      for (int i = 0; i < e.nf; i++) begin
         h  = hb[9 + 3*i] / 16;
         v  = hb[9 + 3*i] % 16;
         tq = hb[10 + 3*i];
         if (!fac_ok(h) || !fac_ok(v)) begin
            e.code = 3'd4; e.err_idx = 9 + 3*i;
            return e;
         end
         if (tq > 3) begin
            e.code = 3'd5; e.err_idx = 10 + 3*i;
            return e;
         end
         e.ids |= 32'(hb[8 + 3*i]) << (8*i);
         e.hs  |= 32'(h)  << (3*i);
         e.vs  |= 32'(v)  << (3*i);
         e.tqs |= 32'(tq) << (2*i);
         if (h > e.hmax) e.hmax = h;
         if (v > e.vmax) e.vmax = v;
      end
      if (e.wd == 0 || e.ht == 0) begin
         e.code = 3'd6; e.err_idx = -1;
         return e;
      end
      e.ok    = 1'b1;
      e.mx    = ((e.wd + 8*e.hmax - 1) / (8*e.hmax)) % 8192;
      e.my    = ((e.ht + 8*e.vmax - 1) / (8*e.vmax)) % 8192;
      e.is420 = (e.hmax == 2) && (e.vmax == 2);
      return e;
   endfunction

   // lf < 0 selects the consistent length 8+3*nf
   function automatic byte_q_t build(input int lf, input int p, input int y, input int x,
                                     input int nf, input logic [31:0] hv4, input logic [31:0] tq4);
      byte_q_t q;
      if (lf < 0) lf = 8 + 3*nf;
      q.push_back(8'(lf >> 8)); q.push_back(8'(lf)); q.push_back(8'(p));
      q.push_back(8'(y >> 8));  q.push_back(8'(y));
      q.push_back(8'(x >> 8));  q.push_back(8'(x));
      q.push_back(8'(nf));
      for (int i = 0; i < nf; i++) begin
         q.push_back(8'(i + 1));
         q.push_back(hv4[8*(i%4) +: 8]);
         q.push_back(tq4[8*(i%4) +: 8]);
      end
      while (q.size() < lf) q.push_back(8'($urandom));
      return q;
   endfunction

   function automatic logic [3:0] rand_fac();
      if ($urandom_range(0, 19) == 0) return 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
         0:       return 4'd1;
         1:       return 4'd2;
         default: return 4'd4;
      endcase
   endfunction

   function automatic byte_q_t rand_hdr();
      int nf, lf, p, y, x;
      logic [31:0] hv, tq;
      nf = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : $urandom_range(1, 3);
      lf = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 30) : -1;
      p  = ($urandom_range(0, 9) == 0) ? 12 : 8;
      y  = ($urandom_range(0, 14) == 0) ? 0 : $urandom_range(1, 3000);
      x  = ($urandom_range(0, 14) == 0) ? 0 : $urandom_range(1, 3000);
      for (int i = 0; i < 4; i++) begin
         hv[8*i +: 8] = {rand_fac(), rand_fac()};
         tq[8*i +: 8] = ($urandom_range(0, 14) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      end
      return build(lf, p, y, x, nf, hv, tq);
   endfunction

   // Presents one byte at a negedge; returns at the negedge after it is accepted
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int t;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            in_data = 8'($urandom);
            @(negedge clk);
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (!in_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic run_header(input byte_q_t hb, input bit gaps);
      exp_t e;
      e = model(hb);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_valid", sof_valid, 0);
      check("start_err", sof_err, 0);
      check("start_height", height, 0);
      check("start_ready", in_ready, 1);
      for (int i = 0; i < e.consumed; i++) begin
         send_byte(hb[i], gaps);
         if (i == e.err_idx) begin
            check("err_edge", sof_err, 1);
            check("err_code_edge", err_code, e.code);
         end
      end
      if (e.err_idx == -2 || e.err_idx == -1) begin
         check("calc_valid", sof_valid, 0);
         check("calc_err", sof_err, 0);
         check("calc_ready", in_ready, 0);
      end
      @(negedge clk);
      check("sof_valid", sof_valid, e.ok);
      check("sof_err", sof_err, !e.ok);
      check("err_code", err_code, e.code);
      check("end_ready", in_ready, 0);
      if (e.ok) begin
         check("precision", precision, e.prec);
         check("height", height, e.ht);
         check("width", width, e.wd);
         check("num_comp", num_comp, e.nf);
         check("comp_id", comp_id, e.ids);
         check("comp_h", comp_h, e.hs);
         check("comp_v", comp_v, e.vs);
         check("comp_tq", comp_tq, e.tqs);
         check("h_max", h_max, e.hmax);
         check("v_max", v_max, e.vmax);
         check("mcus_x", mcus_x, e.mx);
         check("mcus_y", mcus_y, e.my);
         check("is420", pic_is_420, e.is420);
      end
      @(negedge clk);
      check("hold_ready", in_ready, 0);
      check("hold_valid", sof_valid, e.ok);
   endtask

   initial begin
      byte_q_t q;
      rst = 1'b0; clear = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_ready", in_ready, 0);
      check("rst_valid", sof_valid, 0);
      check("rst_err", sof_err, 0);
      check("rst_code", err_code, 0);
      check("rst_mcus", {mcus_x, mcus_y}, 0);
      rst = 1'b1;
      @(negedge clk);

      run_header(build(-1, 8, 480, 640, 3, 32'h00111122, 32'h00010100), 1'b0);
      check("vga_mx", mcus_x, 40);
      check("vga_my", mcus_y, 30);
      check("vga_420", pic_is_420, 1);

      for (int g = 0; g < 2; g++) begin
         run_header(build(-1, 8, 9, 17, 3, 32'h00111121, 32'h00010100), g[0]);
         check("odd_mx", mcus_x, 2);
         check("odd_my", mcus_y, 2);
         check("odd_420", pic_is_420, 0);
      end

      run_header(build(-1, 8, 1, 1, 1, 32'h00000011, 32'h0), 1'b0);
      check("gray_mcus", {mcus_x, mcus_y}, {13'd1, 13'd1});
      check("gray_slots", comp_id[23:8], 0);

      run_header(build(20, 8, 16, 16, 4, 32'h11111111, 32'h0), 1'b0);
      check("ncomp_code", err_code, 3);
      check("ncomp_valid", sof_valid, 0);

      run_header(build(-1, 8, 16, 16, 3, 32'h00111131, 32'h0), 1'b1);
      check("factor_code", err_code, 4);

      run_header(build(5, 8, 16, 16, 3, 32'h00111111, 32'h0), 1'b0);
      check("badlen_code", err_code, 1);

      // Abandon a header mid-C_HV; the restart must reflect only the second one
      q = build(-1, 8, 100, 200, 3, 32'h00111122, 32'h0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) send_byte(q[i], 1'b0);
      run_header(build(-1, 8, 32, 48, 1, 32'h00000011, 32'h00000002), 1'b0);

      clear = 1'b1; start = 1'b1;
      @(negedge clk);
      clear = 1'b0; start = 1'b0;
      check("clr_ready", in_ready, 0);
      check("clr_valid", sof_valid, 0);
      check("clr_width", width, 0);
      check("clr_mcus", mcus_x, 0);
      @(negedge clk);
      check("clr_idle", in_ready, 0);

      run_header(build(-1, 8, 64, 64, 2, 32'h00001122, 32'h0), 1'b0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("rst_done_valid", sof_valid, 0);
      check("rst_done_width", width, 0);
      check("rst_done_id", comp_id, 0);
      check("rst_done_hmax", h_max, 0);

      for (int n = 0; n < 40; n++) run_header(rand_hdr(), n[0]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
